// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory broadcast controller.
package imem_pkg;

  localparam int unsigned MAX_CORES   = 16;
  localparam int unsigned MAX_ROM_LAT = 4;
  localparam int unsigned LEAD_W      = 4;  // index width for up to MAX_CORES cores
  localparam int unsigned LAT_W       = 2;  // holds ROM_LAT-1 for ROM_LAT up to MAX_ROM_LAT

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DELIVER = 2'd3
  } state_e;

endpackage

// File: rtl/imem_lead_sel.sv
// Priority encoder: picks the lowest-index active core as the fetch leader.
module imem_lead_sel
  import imem_pkg::*;
#(
  parameter int unsigned NUM_CORES = 8
) (
  input  logic [NUM_CORES-1:0] active_i,
  output logic [LEAD_W-1:0]    lead_o,
  output logic                 any_o
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    lead_o = '0;
    any_o  = |active_i;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (active_i[i]) lead_o = LEAD_W'(i);
    end
  end

endmodule

// File: rtl/imem_bcast_ctrl.sv
// Broadcasts one IROM fetch to all participating (non-halted) cores.
module imem_bcast_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_CORES = 8,
  parameter int unsigned ROM_LAT   = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_CORES-1:0]         core_req,
  input  logic [NUM_CORES-1:0]         core_halt,
  input  logic [NUM_CORES*WIDTH-1:0]   core_pc,
  input  logic [WIDTH-1:0]             rom_ins,
  output logic                         rom_en,
  output logic [WIDTH-1:0]             rom_addr,
  output logic [NUM_CORES*WIDTH-1:0]   core_ins,
  output logic [NUM_CORES-1:0]         core_av,
  output logic                         pc_mismatch,
  output logic                         all_halted,
  output logic [CNT_W-1:0]             fetch_count
);

  state_e                       state_q, state_d;
  logic [NUM_CORES-1:0]         issue_mask_q, issue_mask_d;
  logic [WIDTH-1:0]             rom_addr_q, rom_addr_d;
  logic                         rom_en_q, rom_en_d;
  logic [LAT_W-1:0]             lat_cnt_q, lat_cnt_d;
  logic [NUM_CORES*WIDTH-1:0]   core_ins_q, core_ins_d;
  logic [NUM_CORES-1:0]         core_av_q, core_av_d;
  logic                         pc_mm_q, pc_mm_d;
  logic                         all_halted_q;
  logic [CNT_W-1:0]             fetch_cnt_q, fetch_cnt_d;

  logic [NUM_CORES-1:0]         active;
  logic [LEAD_W-1:0]            lead;
  logic                         any_active;
  logic [WIDTH-1:0]             lead_pc;
  logic                         pc_diff;
  logic                         issue_go;

  assign active = ~core_halt;

  imem_lead_sel #(
    .NUM_CORES (NUM_CORES)
  ) u_lead_sel (
    .active_i (active),
    .lead_o   (lead),
    .any_o    (any_active)
  );

  // Leader PC mux and divergence detect across active cores.
  always_comb begin
    lead_pc = '0;
    pc_diff = 1'b0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (LEAD_W'(i) == lead) lead_pc = core_pc[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (active[i] && (core_pc[i*WIDTH +: WIDTH] != lead_pc)) pc_diff = 1'b1;
    end
  end

  // Requests from halted cores are masked out; at least one core must be active.
  assign issue_go = any_active && ((core_req & active) == active);

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (issue_go) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_WAIT;
      ST_WAIT:    if (lat_cnt_q == '0) state_d = ST_DELIVER;
      ST_DELIVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; pulses are set one cycle ahead so they are registered.
  always_comb begin
    issue_mask_d = issue_mask_q;
    rom_addr_d   = rom_addr_q;
    rom_en_d     = 1'b0;
    lat_cnt_d    = lat_cnt_q;
    core_ins_d   = core_ins_q;
    core_av_d    = '0;
    pc_mm_d      = pc_mm_q;
    fetch_cnt_d  = fetch_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_go) begin
          issue_mask_d = active;
          rom_addr_d   = lead_pc;
          pc_mm_d      = pc_mm_q | pc_diff;
          rom_en_d     = 1'b1;
        end
      end
      ST_ISSUE: begin
        lat_cnt_d = LAT_W'(ROM_LAT - 1);
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (issue_mask_q[i]) core_ins_d[i*WIDTH +: WIDTH] = rom_ins;
          end
          core_av_d   = issue_mask_q;
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      issue_mask_q <= '0;
      rom_addr_q   <= '0;
      rom_en_q     <= 1'b0;
      lat_cnt_q    <= '0;
      core_ins_q   <= '0;
      core_av_q    <= '0;
      pc_mm_q      <= 1'b0;
      all_halted_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      issue_mask_q <= issue_mask_d;
      rom_addr_q   <= rom_addr_d;
      rom_en_q     <= rom_en_d;
      lat_cnt_q    <= lat_cnt_d;
      core_ins_q   <= core_ins_d;
      core_av_q    <= core_av_d;
      pc_mm_q      <= pc_mm_d;
      all_halted_q <= &core_halt;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign rom_en      = rom_en_q;
  assign rom_addr    = rom_addr_q;
  assign core_ins    = core_ins_q;
  assign core_av     = core_av_q;
  assign pc_mismatch = pc_mm_q;
  assign all_halted  = all_halted_q;
  assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_imem_bcast_ctrl.sv
// Directed bench: instance A (ROM_LAT=1, CNT_W=16) and instance B (ROM_LAT=3, CNT_W=4).
module tb_imem_bcast_ctrl;

  logic Clk = 1'b0;
  logic Rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Instance A signals
  logic [7:0]  a_req, a_halt, a_rom_ins, a_rom_addr, a_av, a_rom_val;
  logic [63:0] a_pc, a_ins;
  logic        a_rom_en, a_mm, a_allh;
  logic [15:0] a_cnt;

  // Instance B signals
  logic [7:0]  b_req, b_halt, b_rom_ins, b_rom_addr, b_av, b_rom_val;
  logic [63:0] b_pc, b_ins;
  logic        b_rom_en, b_mm, b_allh;
  logic [3:0]  b_cnt;

  imem_bcast_ctrl #(.WIDTH(8), .NUM_CORES(8), .ROM_LAT(1), .CNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .core_req(a_req), .core_halt(a_halt), .core_pc(a_pc),
    .rom_ins(a_rom_ins), .rom_en(a_rom_en), .rom_addr(a_rom_addr), .core_ins(a_ins),
    .core_av(a_av), .pc_mismatch(a_mm), .all_halted(a_allh), .fetch_count(a_cnt)
  );

  imem_bcast_ctrl #(.WIDTH(8), .NUM_CORES(8), .ROM_LAT(3), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .core_req(b_req), .core_halt(b_halt), .core_pc(b_pc),
    .rom_ins(b_rom_ins), .rom_en(b_rom_en), .rom_addr(b_rom_addr), .core_ins(b_ins),
    .core_av(b_av), .pc_mismatch(b_mm), .all_halted(b_allh), .fetch_count(b_cnt)
  );

  // IROM models: word valid exactly ROM_LAT cycles after rom_en is sampled, 0xEE otherwise.
  logic       a_vld = 1'b0;
  logic [7:0] a_dat = '0;
  always @(posedge Clk) begin
    a_vld <= a_rom_en;
    a_dat <= a_rom_val;
  end
  assign a_rom_ins = a_vld ? a_dat : 8'hEE;

  logic [2:0] b_vld = '0;
  logic [7:0] b_d0 = '0, b_d1 = '0, b_d2 = '0;
  always @(posedge Clk) begin
    b_vld <= {b_vld[1:0], b_rom_en};
    b_d0  <= b_rom_val;
    b_d1  <= b_d0;
    b_d2  <= b_d1;
  end
  assign b_rom_ins = b_vld[2] ? b_d2 : 8'hEE;

  function automatic logic [63:0] rep8(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic test_reset();
    Rst = 1'b1;
    a_req = '0; a_halt = 8'hFF; a_pc = '0; a_rom_val = '0;
    b_req = '0; b_halt = 8'hFF; b_pc = '0; b_rom_val = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({a_rom_en, a_rom_addr, a_av, a_mm, a_allh} !== 19'd0) begin
      errors++; $display("FAIL reset_a_ctl: got %0h expected 0", {a_rom_en, a_rom_addr, a_av, a_mm, a_allh});
    end
    checks++;
    if (a_ins !== 64'd0 || a_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_a_data: ins=%0h cnt=%0d expected 0/0", a_ins, a_cnt);
    end
    checks++;
    if ({b_rom_en, b_rom_addr, b_av, b_mm, b_allh, b_cnt} !== 23'd0 || b_ins !== 64'd0) begin
      errors++; $display("FAIL reset_b: got %0h/%0h expected 0", {b_rom_en, b_rom_addr, b_av, b_mm, b_allh, b_cnt}, b_ins);
    end
    a_halt = '0; b_halt = '0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    a_halt = '0; a_req = 8'hFF; a_pc = rep8(8'h10); a_rom_val = 8'hA5;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b1 || a_rom_addr !== 8'h10) begin
      errors++; $display("FAIL basic_issue: en=%0b addr=%0h expected 1/10", a_rom_en, a_rom_addr);
    end
    a_req = '0;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b0 || a_av !== 8'h00) begin
      errors++; $display("FAIL basic_wait: en=%0b av=%0h expected 0/00", a_rom_en, a_av);
    end
    @(negedge Clk);
    checks++;
    if (a_av !== 8'hFF || a_ins !== rep8(8'hA5) || a_cnt !== 16'd1) begin
      errors++; $display("FAIL basic_deliver: av=%0h ins=%0h cnt=%0d expected ff/a5..a5/1", a_av, a_ins, a_cnt);
    end
    @(negedge Clk);
    checks++;
    if (a_av !== 8'h00) begin
      errors++; $display("FAIL basic_av_pulse: av=%0h expected 00", a_av);
    end
  endtask

  task automatic test_halt_pattern();
    logic [63:0] exp_ins;
    a_halt = 8'h05; a_req = 8'hFA; a_pc = rep8(8'h22); a_rom_val = 8'h3C;
    a_pc[7:0] = 8'h99; a_pc[23:16] = 8'h98;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b1 || a_rom_addr !== 8'h22) begin
      errors++; $display("FAIL halt_issue: en=%0b addr=%0h expected 1/22", a_rom_en, a_rom_addr);
    end
    a_req = '0;
    repeat (2) @(negedge Clk);
    exp_ins = rep8(8'h3C);
    exp_ins[7:0] = 8'hA5; exp_ins[23:16] = 8'hA5;
    checks++;
    if (a_av !== 8'hFA || a_ins !== exp_ins) begin
      errors++; $display("FAIL halt_deliver: av=%0h ins=%0h expected fa/%0h", a_av, a_ins, exp_ins);
    end
    checks++;
    if (a_mm !== 1'b0 || a_cnt !== 16'd2) begin
      errors++; $display("FAIL halt_mm_cnt: mm=%0b cnt=%0d expected 0/2", a_mm, a_cnt);
    end
    @(negedge Clk);
  endtask

  task automatic test_partial_req();
    int en_seen;
    a_halt = 8'h01; a_req = 8'hFC; a_pc = rep8(8'h33); a_rom_val = 8'h4D;
    en_seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (a_rom_en === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin
      errors++; $display("FAIL partial_no_issue: rom_en pulses=%0d expected 0", en_seen);
    end
    a_req = 8'hFE;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b1 || a_rom_addr !== 8'h33) begin
      errors++; $display("FAIL partial_issue: en=%0b addr=%0h expected 1/33", a_rom_en, a_rom_addr);
    end
    a_req = '0;
    en_seen = 0;
    repeat (10) begin
      @(negedge Clk);
      if (a_rom_en === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0 || a_cnt !== 16'd3 || a_ins[15:8] !== 8'h4D || a_ins[7:0] !== 8'hA5) begin
      errors++; $display("FAIL partial_single: extra_en=%0d cnt=%0d s1=%0h s0=%0h expected 0/3/4d/a5",
                         en_seen, a_cnt, a_ins[15:8], a_ins[7:0]);
    end
  endtask

  task automatic test_halt_midfetch();
    int en_seen;
    a_halt = '0; a_req = 8'hFF; a_pc = rep8(8'h30); a_rom_val = 8'h5A;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b1) begin
      errors++; $display("FAIL mid_issue: en=%0b expected 1", a_rom_en);
    end
    a_req = '0;
    @(negedge Clk);
    a_halt = 8'h04;
    @(negedge Clk);
    checks++;
    if (a_av !== 8'hFF || a_ins[23:16] !== 8'h5A || a_cnt !== 16'd4) begin
      errors++; $display("FAIL mid_deliver: av=%0h s2=%0h cnt=%0d expected ff/5a/4", a_av, a_ins[23:16], a_cnt);
    end
    a_halt = 8'hFF; a_req = 8'hFF;
    @(negedge Clk);
    checks++;
    if (a_allh !== 1'b1) begin
      errors++; $display("FAIL all_halted: got %0b expected 1", a_allh);
    end
    en_seen = 0;
    repeat (10) begin
      @(negedge Clk);
      if (a_rom_en === 1'b1) en_seen++;
    end
    checks++;
    if (en_seen != 0) begin
      errors++; $display("FAIL all_halted_no_fetch: rom_en pulses=%0d expected 0", en_seen);
    end
    a_halt = '0; a_req = '0;
    @(negedge Clk);
  endtask

  task automatic test_reset_abort();
    int av_seen;
    a_req = 8'hFF; a_pc = rep8(8'h44); a_rom_val = 8'h77;
    @(negedge Clk);
    checks++;
    if (a_rom_en !== 1'b1 || a_rom_addr !== 8'h44) begin
      errors++; $display("FAIL abort_issue: en=%0b addr=%0h expected 1/44", a_rom_en, a_rom_addr);
    end
    a_req = '0;
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    checks++;
    if ({a_rom_en, a_rom_addr, a_av, a_allh} !== 18'd0 || a_ins !== 64'd0 || a_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_reset: ctl=%0h ins=%0h cnt=%0d expected 0/0/0",
                         {a_rom_en, a_rom_addr, a_av, a_allh}, a_ins, a_cnt);
    end
    @(negedge Clk);
    Rst = 1'b0;
    av_seen = 0;
    repeat (6) begin
      @(negedge Clk);
      if (a_av !== 8'h00) av_seen++;
    end
    checks++;
    if (av_seen != 0 || a_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_no_av: av cycles=%0d cnt=%0d expected 0/0", av_seen, a_cnt);
    end
  endtask

  task automatic test_divergence();
    int av_early;
    b_halt = '0; b_req = 8'hFF; b_pc = rep8(8'h40); b_pc[31:24] = 8'h41; b_rom_val = 8'h6B;
    @(negedge Clk);
    checks++;
    if (b_rom_en !== 1'b1 || b_rom_addr !== 8'h40) begin
      errors++; $display("FAIL div_issue: en=%0b addr=%0h expected 1/40", b_rom_en, b_rom_addr);
    end
    b_req = '0;
    av_early = 0;
    repeat (3) begin
      @(negedge Clk);
      if (b_av !== 8'h00) av_early++;
    end
    checks++;
    if (av_early != 0) begin
      errors++; $display("FAIL div_latency: early av cycles=%0d expected 0", av_early);
    end
    @(negedge Clk);
    checks++;
    if (b_av !== 8'hFF || b_ins !== rep8(8'h6B) || b_mm !== 1'b1) begin
      errors++; $display("FAIL div_deliver: av=%0h ins=%0h mm=%0b expected ff/6b..6b/1", b_av, b_ins, b_mm);
    end
    @(negedge Clk);
    b_req = 8'hFF; b_pc = rep8(8'h50); b_rom_val = 8'h12;
    @(negedge Clk);
    b_req = '0;
    repeat (4) @(negedge Clk);
    checks++;
    if (b_av !== 8'hFF || b_ins !== rep8(8'h12) || b_mm !== 1'b1 || b_cnt !== 4'd2) begin
      errors++; $display("FAIL div_sticky: av=%0h ins=%0h mm=%0b cnt=%0d expected ff/12..12/1/2",
                         b_av, b_ins, b_mm, b_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n, last, extra;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    b_halt = '0; b_req = 8'hFF; b_pc = rep8(8'h60); b_rom_val = 8'h21;
    n = 0; last = 0;
    for (int k = 0; k < 200 && n < 17; k++) begin
      @(negedge Clk);
      if (b_rom_en === 1'b1) begin
        n++;
        if (n > 1) begin
          checks++;
          if (cyc - last != 6) begin
            errors++; $display("FAIL b2b_spacing: fetch %0d gap=%0d expected 6", n, cyc - last);
          end
        end
        last = cyc;
        if (n == 17) b_req = '0;
      end
    end
    checks++;
    if (n != 17) begin
      errors++; $display("FAIL b2b_timeout: fetches=%0d expected 17", n);
    end
    b_req = '0;
    extra = 0;
    repeat (8) begin
      @(negedge Clk);
      if (b_rom_en === 1'b1) extra++;
    end
    checks++;
    if (extra != 0 || b_cnt !== 4'd1 || b_ins !== rep8(8'h21)) begin
      errors++; $display("FAIL b2b_wrap: extra=%0d cnt=%0d ins=%0h expected 0/1/21..21", extra, b_cnt, b_ins);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt_pattern();
    test_partial_req();
    test_halt_midfetch();
    test_reset_abort();
    test_divergence();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
